// File: rtl/led_mode_ctrl.sv
// Purpose: sequences the seller LED display (idle/1..4 coins/flash/pulse) from seller-FSM events.
// Latency: registered selects, mode changes show 1 cycle later (2 with LED_BLANK_EN, which adds a blank cycle).
// Backpressure: none; events are always accepted, a vend seen during flash is queued one deep.
module led_mode_ctrl #(
    parameter int CNT_W     = 26,
    parameter int FLASH_CYC = 50_000_000,
    parameter int PULSE_CYC = 25_000_000,
    parameter int TMO_CYC   = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] coin_cnt,
    input  logic       evt_vend,
    input  logic       evt_err,
    output logic       led_idle_rst_n,
    output logic       led1_rst_n,
    output logic       led2_rst_n,
    output logic       led3_rst_n,
    output logic       led4_rst_n,
    output logic       led_flash_rst_n,
    output logic       led_pulse_rst_n,
    output logic       busy,
    output logic       tmo
);

    // The shared counter is widened if CNT_W cannot hold the longest programmed hold time.
    localparam int MAX_AB  = (FLASH_CYC > PULSE_CYC) ? FLASH_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_AB > TMO_CYC) ? MAX_AB : TMO_CYC;
    localparam int NEED_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int CW      = (CNT_W > NEED_W) ? CNT_W : NEED_W;

    localparam logic [CW-1:0] FLASH_LD = CW'(FLASH_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] TMO_LD   = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_FLASH = 2'd2;
    localparam logic [1:0] ST_PULSE = 2'd3;

    // Select vector bit order: idle, led1..led4, flash, pulse (bit 0 = idle).
    localparam logic [6:0] SEL_BLANK = 7'b111_1111;
    localparam logic [6:0] SEL_IDLE  = 7'b111_1110;
    localparam logic [6:0] SEL_L1    = 7'b111_1101;
    localparam logic [6:0] SEL_L2    = 7'b111_1011;
    localparam logic [6:0] SEL_L3    = 7'b111_0111;
    localparam logic [6:0] SEL_L4    = 7'b110_1111;
    localparam logic [6:0] SEL_FLASH = 7'b101_1111;
    localparam logic [6:0] SEL_PULSE = 7'b011_1111;

    logic [1:0]    state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          vend_pend_q, vend_pend_nxt;
    logic          tmo_hold_q, tmo_hold_nxt;
    logic [2:0]    coin_prev_q;
    logic [6:0]    sel_q, sel_tgt, sel_nxt;
    logic          busy_q, tmo_q, tmo_nxt;
    logic          coin_chg, coin_nz, cnt_zero;

    function automatic logic [6:0] sel_for(input logic [1:0] st, input logic [2:0] coins);
        logic [6:0] s;
        s = SEL_IDLE;
        case (st)
            ST_COUNT: begin
                case (coins)
                    3'd0:    s = SEL_IDLE;
                    3'd1:    s = SEL_L1;
                    3'd2:    s = SEL_L2;
                    3'd3:    s = SEL_L3;
                    default: s = SEL_L4;
                endcase
            end
            ST_FLASH: s = SEL_FLASH;
            ST_PULSE: s = SEL_PULSE;
            default:  s = SEL_IDLE;
        endcase
        return s;
    endfunction

    assign coin_chg = (coin_cnt != coin_prev_q);
    assign coin_nz  = (coin_cnt != 3'd0);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        vend_pend_nxt = vend_pend_q;
        tmo_hold_nxt  = tmo_hold_q;
        tmo_nxt       = 1'b0;
        if (evt_err) begin
            // Error wins everywhere; a simultaneous vend is remembered for after the flash.
            state_nxt     = ST_FLASH;
            cnt_nxt       = FLASH_LD;
            vend_pend_nxt = vend_pend_q | evt_vend;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt_vend) begin
                        state_nxt     = ST_PULSE;
                        cnt_nxt       = PULSE_LD;
                        vend_pend_nxt = 1'b0;
                    end else if (coin_nz && (!tmo_hold_q || coin_chg)) begin
                        state_nxt = ST_COUNT;
                        cnt_nxt   = TMO_LD;
                    end else if (coin_chg) begin
                        tmo_hold_nxt = 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (evt_vend) begin
                        state_nxt     = ST_PULSE;
                        cnt_nxt       = PULSE_LD;
                        vend_pend_nxt = 1'b0;
                    end else if (!coin_nz) begin
                        state_nxt = ST_IDLE;
                    end else if (coin_chg) begin
                        cnt_nxt = TMO_LD;
                    end else if (cnt_zero) begin
                        // Timed out: stay idle until the coin count moves again.
                        state_nxt    = ST_IDLE;
                        tmo_nxt      = 1'b1;
                        tmo_hold_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q - CNT_ONE;
                    end
                end
                ST_FLASH: begin
                    if (evt_vend) begin
                        vend_pend_nxt = 1'b1;
                    end
                    if (cnt_zero) begin
                        if (vend_pend_q || evt_vend) begin
                            state_nxt     = ST_PULSE;
                            cnt_nxt       = PULSE_LD;
                            vend_pend_nxt = 1'b0;
                        end else if (coin_nz) begin
                            state_nxt = ST_COUNT;
                            cnt_nxt   = TMO_LD;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    if (evt_vend) begin
                        cnt_nxt = PULSE_LD;
                    end else if (cnt_zero) begin
                        if (coin_nz) begin
                            state_nxt = ST_COUNT;
                            cnt_nxt   = TMO_LD;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt_q - CNT_ONE;
                    end
                end
            endcase
        end
        if (state_nxt != ST_IDLE) begin
            tmo_hold_nxt = 1'b0;
        end
    end

    assign sel_tgt = sel_for(state_nxt, coin_cnt);

`ifdef LED_BLANK_EN
    logic flash_restart;
    // A restarted flash is blanked too so the restart is visible.
    assign flash_restart = evt_err && (state_q == ST_FLASH);
    assign sel_nxt = (flash_restart || ((sel_tgt != sel_q) && (sel_q != SEL_BLANK))) ?
                     SEL_BLANK : sel_tgt;
`else
    assign sel_nxt = sel_tgt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vend_pend_q <= 1'b0;
            tmo_hold_q  <= 1'b0;
            coin_prev_q <= 3'd0;
            sel_q       <= SEL_IDLE;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            vend_pend_q <= vend_pend_nxt;
            tmo_hold_q  <= tmo_hold_nxt;
            coin_prev_q <= coin_cnt;
            sel_q       <= sel_nxt;
            busy_q      <= (state_nxt == ST_FLASH) || (state_nxt == ST_PULSE);
            tmo_q       <= tmo_nxt;
        end
    end

    assign led_idle_rst_n  = sel_q[0];
    assign led1_rst_n      = sel_q[1];
    assign led2_rst_n      = sel_q[2];
    assign led3_rst_n      = sel_q[3];
    assign led4_rst_n      = sel_q[4];
    assign led_flash_rst_n = sel_q[5];
    assign led_pulse_rst_n = sel_q[6];
    assign busy            = busy_q;
    assign tmo             = tmo_q;

endmodule
